// File: rtl/piano_pkg.sv
// Shared note table and types for the piano tone path.
package piano_pkg;

  localparam int N_NOTES = 8;

  typedef logic [16:0] half_t;
  typedef logic [N_NOTES-1:0][16:0] half_tbl_t;

  typedef enum logic [1:0] {IDLE, PLAY, RELEASE} tone_state_t;

  // Half-period lengths in clk cycles at 50 MHz, C4 (idx 0) .. C5 (idx 7).
  localparam half_tbl_t HALF_PERIOD = {
    17'd47778, 17'd50619, 17'd56818, 17'd63776,
    17'd71586, 17'd75843, 17'd85131, 17'd95556
  };

endpackage

// File: rtl/key_prio_enc.sv
// Lowest-set-bit priority encoder: the lowest-index pressed key wins.
module key_prio_enc #(
  parameter int N  = 8,
  parameter int IW = 3
)(
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[i]) idx = IW'(i);
  end

  assign any = |req;

endmodule

// File: rtl/key_tone_gen.sv
// Keyboard-driven square-wave tone source: sync, priority pick, tone FSM, sample server.
module key_tone_gen
  import piano_pkg::*;
#(
  parameter int                          N_KEYS      = 8,
  parameter int                          SAMPLE_W    = 24,
  parameter logic signed [SAMPLE_W-1:0]  AMP         = 24'sd1048576,
  parameter int                          RELEASE_CYC = 2500000,
  parameter half_tbl_t                   HP_TABLE    = HALF_PERIOD
)(
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_KEYS-1:0]            keys,
  input  logic                         sample_req,
  output logic signed [SAMPLE_W-1:0]   sample,
  output logic                         sample_valid,
  output logic [2:0]                   key_idx,
  output logic                         tone_on
);

  localparam int RW = $clog2(RELEASE_CYC + 1);

  logic [N_KEYS-1:0] ks1, ks;
  logic [2:0]        win;
  logic              any;
  tone_state_t       state;
  half_t             hp_cnt;
  logic [RW-1:0]     rel_cnt;
  logic              phase;

  key_prio_enc #(.N(N_KEYS), .IW(3)) u_enc (
    .req (ks),
    .idx (win),
    .any (any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ks1          <= '0;
      ks           <= '0;
      state        <= IDLE;
      hp_cnt       <= '0;
      rel_cnt      <= '0;
      phase        <= 1'b0;
      key_idx      <= '0;
      tone_on      <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      ks1          <= keys;
      ks           <= ks1;
      sample_valid <= sample_req;
      if (sample_req)
        sample <= !tone_on ? '0 : (phase ? AMP : -AMP);

      case (state)
        IDLE: if (any) begin
          state   <= PLAY;
          key_idx <= win;
          phase   <= 1'b1;
          hp_cnt  <= HP_TABLE[win] - 17'd1;
          tone_on <= 1'b1;
        end
        PLAY, RELEASE: begin
          // A key change restarts the half period and takes priority over a toggle.
          if (any && win != key_idx) begin
            key_idx <= win;
            hp_cnt  <= HP_TABLE[win] - 17'd1;
          end else if (hp_cnt == '0) begin
            phase  <= ~phase;
            hp_cnt <= HP_TABLE[key_idx] - 17'd1;
          end else begin
            hp_cnt <= hp_cnt - 17'd1;
          end

          if (any) begin
            state <= PLAY;
          end else if (state == PLAY) begin
            state   <= RELEASE;
            rel_cnt <= RW'(RELEASE_CYC - 1);
          end else if (rel_cnt == '0) begin
            state   <= IDLE;
            tone_on <= 1'b0;
            phase   <= 1'b0;
            hp_cnt  <= '0;
          end else begin
            rel_cnt <= rel_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_tone_gen.sv
// Directed + randomized bench for key_tone_gen against a time-stamp based tone model.
module tb_key_tone_gen;
  import piano_pkg::*;

  localparam int REL = 300;
  localparam logic signed [23:0] AMP_TB = 24'sd1048576;
  localparam half_tbl_t HP_TB = {17'd20, 17'd21, 17'd24, 17'd27,
                                 17'd30, 17'd32, 17'd36, 17'd40};

  logic clk = 1'b0;
  logic reset;
  logic [7:0] keys;
  logic sample_req;
  logic signed [23:0] sample;
  logic sample_valid;
  logic [2:0] key_idx;
  logic tone_on;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_tone_gen #(
    .N_KEYS(8), .SAMPLE_W(24), .AMP(AMP_TB), .RELEASE_CYC(REL), .HP_TABLE(HP_TB)
  ) dut (
    .clk(clk), .reset(reset), .keys(keys), .sample_req(sample_req),
    .sample(sample), .sample_valid(sample_valid), .key_idx(key_idx), .tone_on(tone_on)
  );

  // Reference model: 0 silent, 1 sounding, 2 fading; events kept as absolute cycle times.
  int          now = 0;
  int          m_mode, m_key, toggle_at, rel_end;
  logic        m_phase, m_tone, m_valid;
  logic [23:0] m_sample;
  logic [7:0]  kh [2];

  task automatic model_reset();
    m_mode = 0; m_key = 0; m_phase = 0; m_tone = 0; m_valid = 0; m_sample = '0;
    toggle_at = 0; rel_end = 0; kh[0] = '0; kh[1] = '0;
  endtask

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_edge(input logic r, input logic [7:0] k, input logic q);
    logic [7:0] seen;
    int w;
    now++;
    if (r) begin model_reset(); return; end
    m_valid = q;
    if (q) m_sample = !m_tone ? 24'd0 : (m_phase ? AMP_TB : -AMP_TB);
    seen = kh[1]; kh[1] = kh[0]; kh[0] = k;
    w = lowest(seen);
    if (m_mode == 0) begin
      if (seen != 0) begin
        m_mode = 1; m_key = w; m_phase = 1; m_tone = 1; toggle_at = now + int'(HP_TB[w]);
      end
    end else begin
      if (seen != 0 && w != m_key) begin
        m_key = w; toggle_at = now + int'(HP_TB[w]);
      end else if (now == toggle_at) begin
        m_phase = ~m_phase; toggle_at = now + int'(HP_TB[m_key]);
      end
      if (seen != 0) m_mode = 1;
      else if (m_mode == 1) begin m_mode = 2; rel_end = now + REL; end
      else if (now == rel_end) begin m_mode = 0; m_tone = 0; m_phase = 0; end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, now);
    end
  endtask

  task automatic cyc(input logic r, input logic [7:0] k, input logic q);
    reset = r; keys = k; sample_req = q;
    @(posedge clk);
    model_edge(r, k, q);
    #1;
    chk("sample_valid", {31'd0, sample_valid}, {31'd0, m_valid});
    chk("sample", {8'd0, sample}, {8'd0, m_sample});
    chk("tone_on", {31'd0, tone_on}, {31'd0, m_tone});
    chk("key_idx", {29'd0, key_idx}, m_key[31:0]);
  endtask

  task automatic run(input int n, input logic [7:0] k);
    for (int i = 0; i < n; i++) cyc(1'b0, k, ($urandom_range(0, 3) == 0));
  endtask

  initial begin
    logic dropped;
    model_reset();
    reset = 1'b1; keys = '0; sample_req = 1'b0;

    // Reset and idle: a request yields a zero sample one cycle later.
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h00, 1'b0);
    chk("rst_tone_on", {31'd0, tone_on}, 32'd0);
    chk("rst_sample", {8'd0, sample}, 32'd0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("idle_valid", {31'd0, sample_valid}, 32'd1);
    chk("idle_sample", {8'd0, sample}, 32'd0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("idle_valid_drop", {31'd0, sample_valid}, 32'd0);

    // A4 press: tone_on rises on the third edge.
    cyc(1'b0, 8'h20, 1'b0);
    chk("a4_lat1", {31'd0, tone_on}, 32'd0);
    cyc(1'b0, 8'h20, 1'b0);
    chk("a4_lat2", {31'd0, tone_on}, 32'd0);
    cyc(1'b0, 8'h20, 1'b0);
    chk("a4_lat3", {31'd0, tone_on}, 32'd1);
    chk("a4_idx", {29'd0, key_idx}, 32'd5);
    run(150, 8'h20);

    // Two keys, then the lower one is dropped.
    run(80, 8'h84);
    chk("two_keys_idx", {29'd0, key_idx}, 32'd2);
    run(3, 8'h80);
    chk("drop_idx", {29'd0, key_idx}, 32'd7);
    run(100, 8'h80);

    // Full release back to silence.
    run(REL + 40, 8'h00);
    chk("release_off", {31'd0, tone_on}, 32'd0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("release_sample", {8'd0, sample}, 32'd0);

    // Re-press during release: tone never drops.
    run(60, 8'h08);
    dropped = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc(1'b0, 8'h00, ($urandom_range(0, 1) == 1));
      if (!tone_on) dropped = 1'b1;
    end
    for (int i = 0; i < 60; i++) begin
      cyc(1'b0, 8'h01, ($urandom_range(0, 1) == 1));
      if (!tone_on) dropped = 1'b1;
    end
    chk("repress_no_drop", {31'd0, dropped}, 32'd0);
    chk("repress_idx", {29'd0, key_idx}, 32'd0);

    // Reset mid-PLAY with key 3 held.
    run(50, 8'h08);
    cyc(1'b1, 8'h08, 1'b0);
    chk("midrst_tone", {31'd0, tone_on}, 32'd0);
    chk("midrst_idx", {29'd0, key_idx}, 32'd0);
    cyc(1'b0, 8'h08, 1'b0);
    cyc(1'b0, 8'h08, 1'b0);
    chk("midrst_lat2", {31'd0, tone_on}, 32'd0);
    cyc(1'b0, 8'h08, 1'b0);
    chk("midrst_lat3", {31'd0, tone_on}, 32'd1);
    chk("midrst_idx3", {29'd0, key_idx}, 32'd3);

    // Back-to-back requests across phase toggles.
    for (int i = 0; i < 40; i++) cyc(1'b0, 8'h08, 1'b1);

    // Random key patterns, holds and requests.
    for (int s = 0; s < 60; s++) begin
      logic [7:0] k;
      k = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      run($urandom_range(1, 70), k);
      if ($urandom_range(0, 15) == 0) cyc(1'b1, k, 1'b0);
    end
    run(REL + 20, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
